// File: rtl/icache_fill_ctrl_if.sv
// Request/beat/write bundle between the icache fill controller, the bus return channel
// and the data array ports. The controller takes the slave modport.
interface icache_fill_ctrl_if #(
  parameter int INDEX_W = 6,
  parameter int WAY_W   = 3
);
  logic               miss_valid;
  logic               miss_ready;
  logic [INDEX_W-1:0] miss_index;
  logic [WAY_W-1:0]   miss_way;
  logic               bus_rvalid;
  logic               bus_rready;
  logic [127:0]       bus_rdata;
  logic               hit_read2data_array_valid;
  logic               hit_read_block;
  logic               fill2data_array_valid;
  logic [INDEX_W-1:0] fill2data_array_index;
  logic [WAY_W-1:0]   fill2data_array_way;
  logic [1:0]         fill2data_array_offset;
  logic [127:0]       fill2data_array_wdata;
  logic               fill_busy;
  logic               fill_done;

  modport master (
    output miss_valid, miss_index, miss_way, bus_rvalid, bus_rdata, hit_read2data_array_valid,
    input  miss_ready, bus_rready, hit_read_block, fill2data_array_valid, fill2data_array_index,
           fill2data_array_way, fill2data_array_offset, fill2data_array_wdata, fill_busy, fill_done
  );

  modport slave (
    input  miss_valid, miss_index, miss_way, bus_rvalid, bus_rdata, hit_read2data_array_valid,
    output miss_ready, bus_rready, hit_read_block, fill2data_array_valid, fill2data_array_index,
           fill2data_array_way, fill2data_array_offset, fill2data_array_wdata, fill_busy, fill_done
  );
endinterface

// File: rtl/icache_fill_ctrl.sv
// Icache line refill sequencer: buffers bus beats and writes them into idle data-array slots.
// Optional ICACHE_FILL_BYPASS_EN: a beat arriving at an empty FIFO on a free slot is written directly.
module icache_fill_ctrl #(
  parameter int BEATS      = 4,
  parameter int DEPTH      = 2,
  parameter int INDEX_W    = 6,
  parameter int WAY_W      = 3,
  parameter int STARVE_MAX = 8
) (
  input  logic              clock,
  input  logic              reset,
  icache_fill_ctrl_if.slave io
);
  localparam int OW = $clog2(BEATS);
  localparam int CW = $clog2(BEATS + 1);
  localparam int AW = $clog2(DEPTH);
  localparam int SW = (STARVE_MAX > 1) ? $clog2(STARVE_MAX) : 1;

  typedef enum logic [1:0] {IDLE, FILL, DONE} state_t;
  typedef struct packed {
    logic [INDEX_W-1:0] index;
    logic [WAY_W-1:0]   way;
  } tgt_t;

  state_t        state, state_nxt;
  tgt_t          tgt_q;
  logic [127:0]  mem [DEPTH];
  logic [AW:0]   wptr, rptr, occ;
  logic [CW-1:0] rx_cnt;
  logic [OW-1:0] wr_cnt;
  logic [SW-1:0] stall_cnt;
  logic          block_q;
  logic          in_fill, empty, full, hit, rready, rx_fire;
  logic          bypass, wr_en, push, pop, stall_inc, last, miss_ready;
  logic [127:0]  head;

  assign occ     = wptr - rptr;
  assign empty   = (occ == '0);
  assign full    = (occ == (AW+1)'(DEPTH));
  assign in_fill = (state == FILL);
  assign hit     = io.hit_read2data_array_valid;
  // Occupancy before any same-cycle pop decides readiness, so a full FIFO never takes a beat.
  assign rready  = in_fill && !full && (rx_cnt < CW'(BEATS));
  assign rx_fire = io.bus_rvalid && rready;
  assign head    = empty ? '0 : mem[rptr[AW-1:0]];

`ifdef ICACHE_FILL_BYPASS_EN
  assign bypass = in_fill && empty && rx_fire && !hit;
  assign io.fill2data_array_wdata = bypass ? io.bus_rdata : head;
`else
  assign bypass = 1'b0;
  assign io.fill2data_array_wdata = head;
`endif

  // hit_read always owns the array; fill only takes otherwise-idle cycles.
  assign wr_en     = (in_fill && !empty && !hit) || bypass;
  assign push      = rx_fire && !bypass;
  assign pop       = wr_en && !bypass;
  assign stall_inc = in_fill && !empty && hit;
  assign last      = wr_en && (wr_cnt == OW'(BEATS - 1));

  always_ff @(posedge clock or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    miss_ready = 1'b0;
    case (state)
      IDLE: begin
        miss_ready = 1'b1;
        if (io.miss_valid) state_nxt = FILL;
      end
      FILL:    if (last) state_nxt = DONE;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      tgt_q     <= '0;
      wptr      <= '0;
      rptr      <= '0;
      rx_cnt    <= '0;
      wr_cnt    <= '0;
      stall_cnt <= '0;
      block_q   <= 1'b0;
    end else begin
      block_q <= 1'b0;
      if (state == IDLE && io.miss_valid) begin
        tgt_q     <= '{index: io.miss_index, way: io.miss_way};
        wptr      <= '0;
        rptr      <= '0;
        rx_cnt    <= '0;
        wr_cnt    <= '0;
        stall_cnt <= '0;
      end else begin
        if (push)    wptr   <= wptr + (AW+1)'(1);
        if (pop)     rptr   <= rptr + (AW+1)'(1);
        if (rx_fire) rx_cnt <= rx_cnt + CW'(1);
        if (wr_en)   wr_cnt <= wr_cnt + OW'(1);
        // Starvation: after STARVE_MAX blocked cycles, ask upstream to skip one hit_read.
        if (wr_en) stall_cnt <= '0;
        else if (stall_inc) begin
          if (stall_cnt == SW'(STARVE_MAX - 1)) begin
            stall_cnt <= '0;
            block_q   <= 1'b1;
          end else begin
            stall_cnt <= stall_cnt + SW'(1);
          end
        end
      end
    end
  end

  always_ff @(posedge clock) begin
    if (push) mem[wptr[AW-1:0]] <= io.bus_rdata;
  end

  assign io.miss_ready             = miss_ready && !reset;
  assign io.bus_rready             = rready;
  assign io.hit_read_block         = block_q;
  assign io.fill2data_array_valid  = wr_en;
  assign io.fill2data_array_index  = tgt_q.index;
  assign io.fill2data_array_way    = tgt_q.way;
  assign io.fill2data_array_offset = wr_cnt;
  assign io.fill_busy              = (state != IDLE);
  assign io.fill_done              = (state == DONE);
endmodule

// File: tb/tb_icache_fill_ctrl.sv
// Bench for icache_fill_ctrl: directed vector table, hand sequences for starvation/reset/slow bus,
// and random refills checked each cycle against a beat-count reference model.
module tb_icache_fill_ctrl;
  localparam int BEATS = 4, DEPTH = 2, INDEX_W = 6, WAY_W = 3, STARVE_MAX = 8;
`ifdef ICACHE_FILL_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  icache_fill_ctrl_if #(.INDEX_W(INDEX_W), .WAY_W(WAY_W)) io ();
  icache_fill_ctrl #(.BEATS(BEATS), .DEPTH(DEPTH), .INDEX_W(INDEX_W), .WAY_W(WAY_W),
                     .STARVE_MAX(STARVE_MAX)) dut (.clock(clock), .reset(reset), .io(io));

  int n_chk = 0, n_fail = 0;

  task automatic chk(input string nm, input logic [127:0] got, input logic [127:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, exp);
    end
  endtask

  task automatic chk1(input string nm, input logic got, input logic exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b", nm, got, exp);
    end
  endtask

  // Reference model: a line is a sequence of accepted beats that must be written in order,
  // one per cycle whenever a beat is pending and hit_read is idle.
  bit                 m_fill, m_done, m_blk;
  int                 m_acc, m_wr, m_stall;
  logic [127:0]       m_q[$];
  logic [INDEX_W-1:0] m_idx;
  logic [WAY_W-1:0]   m_way;
  int                 n_done, line_wr;
  bit                 s_acc, s_mr, s_rr, s_fv, s_done, s_busy, s_blk;
  logic [1:0]         s_off;
  logic [127:0]       s_wd;
  logic [127:0]       line_b[BEATS];

  task automatic tick();
    bit exp_mr, exp_rr, exp_fv, exp_busy, nxt_blk, hv;
    int qs;
    logic [127:0] exp_wd;
    @(negedge clock);
    if (reset) begin
      m_fill = 0; m_done = 0; m_blk = 0; m_acc = 0; m_wr = 0; m_stall = 0;
      m_q.delete(); m_idx = '0; m_way = '0;
    end
    hv       = io.hit_read2data_array_valid;
    qs       = m_q.size();
    exp_mr   = !reset && !m_fill && !m_done;
    exp_busy = m_fill || m_done;
    exp_rr   = m_fill && (m_acc < BEATS) && (qs < DEPTH);
    s_acc    = io.bus_rvalid && exp_rr;
    exp_fv   = m_fill && !hv && (qs > 0 || (BYP && s_acc));
    exp_wd   = (qs > 0) ? m_q[0] : io.bus_rdata;
    s_mr = io.miss_ready; s_rr = io.bus_rready; s_fv = io.fill2data_array_valid;
    s_done = io.fill_done; s_busy = io.fill_busy; s_blk = io.hit_read_block;
    s_off = io.fill2data_array_offset; s_wd = io.fill2data_array_wdata;
    chk1("miss_ready", s_mr, exp_mr);
    chk1("bus_rready", s_rr, exp_rr);
    chk1("fill_valid", s_fv, exp_fv);
    chk1("fill_busy", s_busy, exp_busy);
    chk1("fill_done", s_done, m_done);
    chk1("hit_read_block", s_blk, m_blk);
    chk("fill_index", 128'(io.fill2data_array_index), 128'(m_idx));
    chk("fill_way", 128'(io.fill2data_array_way), 128'(m_way));
    if (exp_fv) begin
      chk("fill_offset", 128'(s_off), 128'(m_wr));
      chk("fill_wdata", s_wd, exp_wd);
    end
    if (reset) begin
      chk("rst_wdata", s_wd, 128'd0);
      chk("rst_offset", 128'(s_off), 128'd0);
    end
    if (s_fv) line_wr++;
    if (s_done) n_done++;
    if (s_acc) begin m_q.push_back(io.bus_rdata); m_acc++; end
    nxt_blk = 0;
    if (exp_fv) begin
      void'(m_q.pop_front());
      m_wr++;
      m_stall = 0;
    end else if (m_fill && qs > 0 && hv) begin
      m_stall++;
      if (m_stall == STARVE_MAX) begin nxt_blk = 1; m_stall = 0; end
    end
    m_blk = nxt_blk;
    if (m_done) m_done = 0;
    if (exp_fv && m_wr == BEATS) begin m_fill = 0; m_done = 1; end
    if (exp_mr && io.miss_valid) begin
      m_fill = 1; m_idx = io.miss_index; m_way = io.miss_way;
      m_acc = 0; m_wr = 0; m_stall = 0; m_q.delete(); line_wr = 0;
    end
    @(posedge clock);
    #1;
  endtask

  task automatic start_miss(input logic [INDEX_W-1:0] idx, input logic [WAY_W-1:0] way);
    foreach (line_b[k]) line_b[k] = {$urandom, $urandom, $urandom, $urandom};
    io.miss_valid = 1'b1; io.miss_index = idx; io.miss_way = way;
    for (int i = 0; i < 10 && !m_fill; i++) tick();
    io.miss_valid = 1'b0;
    chk1("miss_accepted", m_fill, 1'b1);
  endtask

  // Presents the remaining beats with gaps in [gmin,gmax]; hit_read is random but honours block.
  task automatic feed(input int src0, input int gmin, input int gmax, input int hit_pct, input bit extra);
    int src, gap, cyc, d0;
    src = src0; cyc = 0; d0 = n_done;
    gap = $urandom_range(gmax, gmin);
    while ((m_fill || m_done) && cyc < 300) begin
      io.hit_read2data_array_valid = s_blk ? 1'b0 : ($urandom_range(99, 0) < hit_pct);
      if (src < BEATS && gap == 0) begin
        io.bus_rvalid = 1'b1; io.bus_rdata = line_b[src];
      end else if (src >= BEATS && extra) begin
        io.bus_rvalid = 1'b1; io.bus_rdata = {$urandom, $urandom, $urandom, $urandom};
      end else begin
        io.bus_rvalid = 1'b0;
      end
      tick();
      cyc++;
      if (s_acc) begin src++; gap = $urandom_range(gmax, gmin); end
      else if (gap > 0) gap--;
    end
    io.bus_rvalid = 1'b0;
    io.hit_read2data_array_valid = 1'b0;
    chk1("line_in_budget", cyc < 300, 1'b1);
    chk("line_writes", 128'(line_wr), 128'(BEATS));
    chk("line_done_pulses", 128'(n_done - d0), 128'd1);
  endtask

`ifndef ICACHE_FILL_BYPASS_EN
  typedef struct {
    bit mv; logic [INDEX_W-1:0] mi; logic [WAY_W-1:0] mw;
    bit rv; logic [127:0] bd; bit hv;
    bit e_mr, e_rr, e_fv; logic [1:0] e_off; logic [127:0] e_wd; bit e_done, e_busy;
  } vec_t;
  vec_t tab[$];

  function automatic void add(bit mv, logic [INDEX_W-1:0] mi, logic [WAY_W-1:0] mw, bit rv,
                              logic [127:0] bd, bit hv, bit mr, bit rr, bit fv, logic [1:0] off,
                              logic [127:0] wd, bit dn, bit bz);
    vec_t v;
    v = '{mv, mi, mw, rv, bd, hv, mr, rr, fv, off, wd, dn, bz};
    tab.push_back(v);
  endfunction

  function automatic logic [127:0] dat(input logic [31:0] base, input int k);
    return {4{base + 32'(k)}};
  endfunction
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    io.miss_valid = 0; io.miss_index = '0; io.miss_way = '0;
    io.bus_rvalid = 0; io.bus_rdata = '0; io.hit_read2data_array_valid = 0;
    @(posedge clock);
    #1;
    tick();
    tick();
    reset = 1'b0;

`ifndef ICACHE_FILL_BYPASS_EN
    // idle array, then extra beats held high after the line
    add(1, 6'h2A, 3'd5, 0, '0,                     0, 1, 0, 0, 2'd0, '0,                     0, 0);
    add(0, '0, '0, 1, dat(32'hA000_0000, 0),       0, 0, 1, 0, 2'd0, '0,                     0, 1);
    add(0, '0, '0, 1, dat(32'hA000_0000, 1),       0, 0, 1, 1, 2'd0, dat(32'hA000_0000, 0),  0, 1);
    add(0, '0, '0, 1, dat(32'hA000_0000, 2),       0, 0, 1, 1, 2'd1, dat(32'hA000_0000, 1),  0, 1);
    add(0, '0, '0, 1, dat(32'hA000_0000, 3),       0, 0, 1, 1, 2'd2, dat(32'hA000_0000, 2),  0, 1);
    add(0, '0, '0, 1, dat(32'hBAD0_0000, 0),       0, 0, 0, 1, 2'd3, dat(32'hA000_0000, 3),  0, 1);
    add(0, '0, '0, 1, dat(32'hBAD0_0000, 1),       0, 0, 0, 0, 2'd0, '0,                     1, 1);
    add(0, '0, '0, 1, dat(32'hBAD0_0000, 2),       0, 1, 0, 0, 2'd0, '0,                     0, 0);
    // contention: hit_read for 3 cycles while beat 1 is queued
    add(1, 6'h15, 3'd2, 0, '0,                     0, 1, 0, 0, 2'd0, '0,                     0, 0);
    add(0, '0, '0, 1, dat(32'hE000_0000, 0),       0, 0, 1, 0, 2'd0, '0,                     0, 1);
    add(0, '0, '0, 1, dat(32'hE000_0000, 1),       0, 0, 1, 1, 2'd0, dat(32'hE000_0000, 0),  0, 1);
    add(0, '0, '0, 1, dat(32'hE000_0000, 2),       1, 0, 1, 0, 2'd0, '0,                     0, 1);
    add(0, '0, '0, 1, dat(32'hE000_0000, 3),       1, 0, 0, 0, 2'd0, '0,                     0, 1);
    add(0, '0, '0, 1, dat(32'hE000_0000, 3),       1, 0, 0, 0, 2'd0, '0,                     0, 1);
    add(0, '0, '0, 1, dat(32'hE000_0000, 3),       0, 0, 0, 1, 2'd1, dat(32'hE000_0000, 1),  0, 1);
    add(0, '0, '0, 1, dat(32'hE000_0000, 3),       0, 0, 1, 1, 2'd2, dat(32'hE000_0000, 2),  0, 1);
    add(0, '0, '0, 0, '0,                          0, 0, 0, 1, 2'd3, dat(32'hE000_0000, 3),  0, 1);
    add(0, '0, '0, 0, '0,                          0, 0, 0, 0, 2'd0, '0,                     1, 1);
    add(0, '0, '0, 0, '0,                          0, 1, 0, 0, 2'd0, '0,                     0, 0);
    foreach (tab[i]) begin
      io.miss_valid = tab[i].mv; io.miss_index = tab[i].mi; io.miss_way = tab[i].mw;
      io.bus_rvalid = tab[i].rv; io.bus_rdata = tab[i].bd;
      io.hit_read2data_array_valid = tab[i].hv;
      tick();
      chk1($sformatf("tab%0d_miss_ready", i), s_mr, tab[i].e_mr);
      chk1($sformatf("tab%0d_rready", i), s_rr, tab[i].e_rr);
      chk1($sformatf("tab%0d_fvalid", i), s_fv, tab[i].e_fv);
      chk1($sformatf("tab%0d_done", i), s_done, tab[i].e_done);
      chk1($sformatf("tab%0d_busy", i), s_busy, tab[i].e_busy);
      if (tab[i].e_fv) begin
        chk($sformatf("tab%0d_offset", i), 128'(s_off), 128'(tab[i].e_off));
        chk($sformatf("tab%0d_wdata", i), s_wd, tab[i].e_wd);
      end
    end
    io.miss_valid = 0; io.bus_rvalid = 0; io.hit_read2data_array_valid = 0;
`endif

    // starvation: beat 0 queued, hit_read held until block, then released
    start_miss(6'h11, 3'd3);
    io.bus_rvalid = 1; io.bus_rdata = line_b[0]; io.hit_read2data_array_valid = 1;
    tick();
    io.bus_rvalid = 0;
    for (int k = 1; k <= STARVE_MAX + 1; k++) begin
      tick();
      chk1($sformatf("starve_block_k%0d", k), s_blk, k == STARVE_MAX + 1);
      chk1($sformatf("starve_nowrite_k%0d", k), s_fv, 1'b0);
    end
    io.hit_read2data_array_valid = 0;
    tick();
    chk1("starve_release_write", s_fv, 1'b1);
    chk("starve_release_offset", 128'(s_off), 128'd0);
    chk1("starve_block_one_cycle", s_blk, 1'b0);
    feed(1, 0, 1, 0, 0);

    // slow bus: beats three cycles apart
    start_miss(6'h2B, 3'd4);
    feed(0, 2, 2, 0, 0);

    // reset after two writes, then a fresh line
    begin
      int src, cyc, d0;
      start_miss(6'h3F, 3'd7);
      src = 0; cyc = 0; d0 = n_done;
      while (line_wr < 2 && cyc < 20) begin
        io.bus_rvalid = (src < BEATS);
        io.bus_rdata = line_b[(src < BEATS) ? src : 0];
        tick();
        cyc++;
        if (s_acc) src++;
      end
      chk("rst_two_writes_seen", 128'(line_wr), 128'd2);
      io.bus_rvalid = 0;
      reset = 1'b1;
      tick();
      chk1("rst_outputs_zero", s_mr | s_rr | s_fv | s_done | s_busy | s_blk, 1'b0);
      tick();
      reset = 1'b0;
      tick();
      chk1("rst_ready_after", s_mr, 1'b1);
      chk("rst_no_done", 128'(n_done - d0), 128'd0);
      start_miss(6'h0C, 3'd1);
      feed(0, 0, 0, 0, 0);
    end

    // random refills, back-to-back or with short idle gaps
    for (int l = 0; l < 25; l++) begin
      start_miss(INDEX_W'($urandom), WAY_W'($urandom));
      feed(0, 0, $urandom_range(3, 0), $urandom_range(60, 0), 1'($urandom_range(1, 0)));
      for (int g = 0; g < int'($urandom_range(2, 0)); g++) tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
